// File: rtl/adc_avg_pkg.sv
// Shared types, default sizing and the rounding helper for the per-channel averager.
package adc_avg_pkg;

   localparam int DIN_WIDTH_DEF = 8;
   localparam int CH_WIDTH_DEF  = 3;
   localparam int AVG_LOG2_DEF  = 4;

   // Sizing derived from the default parameter set; instances recompute their own.
   localparam int NUM_CH = 2 ** CH_WIDTH_DEF;
   localparam int ACC_W  = DIN_WIDTH_DEF + AVG_LOG2_DEF;

   typedef enum logic [0:0] {
      OUT_EMPTY = 1'b0,
      OUT_FULL  = 1'b1
   } out_state_t;

   // Round-half-up mean of a group of 2^avg_log2 samples; no rounding term for groups of one.
   function automatic logic [31:0] mean_f(input logic [31:0] sum, input int avg_log2);
      logic [31:0] res;
      if (avg_log2 == 0) begin
         res = sum;
      end else begin
         res = (sum + (32'd1 << (avg_log2 - 1))) >> avg_log2;
      end
      return res;
   endfunction

endpackage

// File: rtl/adc_chan_avg_if.sv
// AXI-Stream style bus carrying one sample and its channel tag per beat.
interface axistream_if #(
   parameter int DWIDTH     = 8,
   parameter int USER_WIDTH = 3
) ();

   logic [DWIDTH-1:0]     tdata;
   logic [USER_WIDTH-1:0] tuser;
   logic                  tlast;
   logic                  tvalid;
   logic                  tready;

   modport master (
      output tdata,
      output tuser,
      output tlast,
      output tvalid,
      input  tready
   );

   modport slave (
      input  tdata,
      input  tuser,
      input  tlast,
      input  tvalid,
      output tready
   );

endinterface

// File: rtl/adc_avg_outreg.sv
// Single-entry output register: holds one finished mean until the sink takes it,
// allows drain-and-refill in the same cycle, and counts delivered averages.
module adc_avg_outreg
   import adc_avg_pkg::*;
#(
   parameter int DIN_WIDTH = 8,
   parameter int CH_WIDTH  = 3
) (
   input  logic                 CLK,
   input  logic                 rst,
   input  logic                 load,
   input  logic [DIN_WIDTH-1:0] load_data,
   input  logic [CH_WIDTH-1:0]  load_user,
   output logic                 in_ready,
   axistream_if.master          m_axis,
   output logic [15:0]          groups_done
);

   out_state_t            state_r;
   out_state_t            state_next;
   logic [DIN_WIDTH-1:0]  data_r;
   logic [CH_WIDTH-1:0]   user_r;
   logic [15:0]           done_r;
   logic                  drain;

   assign drain    = (state_r == OUT_FULL) && m_axis.tready;
   assign in_ready = !rst && ((state_r == OUT_EMPTY) || m_axis.tready);

   // Output state register.
   always_ff @(posedge CLK) begin
      if (rst) begin
         state_r <= OUT_EMPTY;
      end else begin
         state_r <= state_next;
      end
   end

   // Next state: a completing group always wins, otherwise a handshake empties the slot.
   always_comb begin
      state_next = state_r;
      case (state_r)
         OUT_EMPTY: begin
            if (load) begin
               state_next = OUT_FULL;
            end else begin
               state_next = OUT_EMPTY;
            end
         end
         OUT_FULL: begin
            if (load) begin
               state_next = OUT_FULL;
            end else if (m_axis.tready) begin
               state_next = OUT_EMPTY;
            end else begin
               state_next = OUT_FULL;
            end
         end
         default: state_next = OUT_EMPTY;
      endcase
   end

   // Payload capture; load only occurs when the slot is empty or draining, so data stays stable under backpressure.
   always_ff @(posedge CLK) begin
      if (rst) begin
         data_r <= {DIN_WIDTH{1'b0}};
         user_r <= {CH_WIDTH{1'b0}};
      end else if (load) begin
         data_r <= load_data;
         user_r <= load_user;
      end else begin
         data_r <= data_r;
         user_r <= user_r;
      end
   end

   // Delivered-average counter, wrapping at 16 bits.
   always_ff @(posedge CLK) begin
      if (rst) begin
         done_r <= 16'd0;
      end else if (drain) begin
         done_r <= done_r + 16'd1;
      end else begin
         done_r <= done_r;
      end
   end

   assign m_axis.tvalid = (state_r == OUT_FULL);
   assign m_axis.tdata  = data_r;
   assign m_axis.tuser  = user_r;
   assign m_axis.tlast  = 1'b0;
   assign groups_done   = done_r;

endmodule

// File: rtl/adc_chan_avg.sv
// Per-channel decimating averager: accumulates 2^AVG_LOG2 samples per channel tag
// and emits one rounded mean per completed group, tagged with its channel.
module adc_chan_avg
   import adc_avg_pkg::*;
#(
   parameter int DIN_WIDTH = 8,
   parameter int CH_WIDTH  = 3,
   parameter int AVG_LOG2  = 4
) (
   input  logic        CLK,
   input  logic        rst,
   axistream_if.slave  s_axis,
   axistream_if.master m_axis,
   input  logic        clear,
   output logic [15:0] groups_done
);

   localparam int N_CH     = 2 ** CH_WIDTH;
   localparam int ACC_BITS = DIN_WIDTH + AVG_LOG2;
   // A zero-width counter is not legal; with one-sample groups the counter stays at zero.
   localparam int CNT_BITS = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
   localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'((2 ** AVG_LOG2) - 1);

   logic [ACC_BITS-1:0]  acc [N_CH];
   logic [CNT_BITS-1:0]  cnt [N_CH];
   logic [CH_WIDTH-1:0]  ch;
   logic                 in_ready;
   logic                 accept;
   logic                 last_beat;
   logic                 complete;
   logic [ACC_BITS-1:0]  sum;
   logic [DIN_WIDTH-1:0] mean;

   assign ch             = s_axis.tuser;
   assign s_axis.tready  = in_ready;
   assign accept         = s_axis.tvalid && in_ready;

   // Read side of the read-modify-write: running sum including this beat and the rounded mean.
   always_comb begin
      sum       = acc[ch] + ACC_BITS'(s_axis.tdata);
      last_beat = (cnt[ch] == CNT_LAST);
      complete  = accept && !clear && last_beat;
      mean      = DIN_WIDTH'(mean_f(32'(sum), AVG_LOG2));
   end

   // Accumulator and group counter arrays; clear drops any beat accepted alongside it.
   always_ff @(posedge CLK) begin
      if (rst || clear) begin
         for (int i = 0; i < N_CH; i++) begin
            acc[i] <= {ACC_BITS{1'b0}};
            cnt[i] <= {CNT_BITS{1'b0}};
         end
      end else if (accept) begin
         if (last_beat) begin
            acc[ch] <= {ACC_BITS{1'b0}};
            cnt[ch] <= {CNT_BITS{1'b0}};
         end else begin
            acc[ch] <= sum;
            cnt[ch] <= cnt[ch] + CNT_BITS'(1);
         end
      end else begin
         for (int i = 0; i < N_CH; i++) begin
            acc[i] <= acc[i];
            cnt[i] <= cnt[i];
         end
      end
   end

   adc_avg_outreg #(
      .DIN_WIDTH (DIN_WIDTH),
      .CH_WIDTH  (CH_WIDTH)
   ) u_outreg (
      .CLK         (CLK),
      .rst         (rst),
      .load        (complete),
      .load_data   (mean),
      .load_user   (ch),
      .in_ready    (in_ready),
      .m_axis      (m_axis),
      .groups_done (groups_done)
   );

endmodule

// File: tb/tb_adc_chan_avg.sv
// Bench for adc_chan_avg: a 4-sample-group instance and a pass-through instance,
// checked every cycle against a per-channel sum/count model plus literal expectations.
module tb_adc_chan_avg;

   logic CLK = 1'b0;
   always #5 CLK = ~CLK;

   logic       rst;
   logic       clear;
   logic       s_tv  [2];
   logic [7:0] s_td  [2];
   logic [2:0] s_tu  [2];
   logic       m_rdy [2];
   logic       o_sr  [2];
   logic       o_mv  [2];
   logic [7:0] o_md  [2];
   logic [2:0] o_mu  [2];
   logic [15:0] gd   [2];

   axistream_if #(.DWIDTH(8), .USER_WIDTH(3)) s_if0 ();
   axistream_if #(.DWIDTH(8), .USER_WIDTH(3)) m_if0 ();
   axistream_if #(.DWIDTH(8), .USER_WIDTH(3)) s_if1 ();
   axistream_if #(.DWIDTH(8), .USER_WIDTH(3)) m_if1 ();

   assign s_if0.tvalid = s_tv[0];
   assign s_if0.tdata  = s_td[0];
   assign s_if0.tuser  = s_tu[0];
   assign s_if0.tlast  = 1'b0;
   assign m_if0.tready = m_rdy[0];
   assign s_if1.tvalid = s_tv[1];
   assign s_if1.tdata  = s_td[1];
   assign s_if1.tuser  = s_tu[1];
   assign s_if1.tlast  = 1'b0;
   assign m_if1.tready = m_rdy[1];

   assign o_sr[0] = s_if0.tready;
   assign o_mv[0] = m_if0.tvalid;
   assign o_md[0] = m_if0.tdata;
   assign o_mu[0] = m_if0.tuser;
   assign o_sr[1] = s_if1.tready;
   assign o_mv[1] = m_if1.tvalid;
   assign o_md[1] = m_if1.tdata;
   assign o_mu[1] = m_if1.tuser;

   adc_chan_avg #(.DIN_WIDTH(8), .CH_WIDTH(3), .AVG_LOG2(2)) dut4 (
      .CLK         (CLK),
      .rst         (rst),
      .s_axis      (s_if0),
      .m_axis      (m_if0),
      .clear       (clear),
      .groups_done (gd[0])
   );

   adc_chan_avg #(.DIN_WIDTH(8), .CH_WIDTH(3), .AVG_LOG2(0)) dut1 (
      .CLK         (CLK),
      .rst         (rst),
      .s_axis      (s_if1),
      .m_axis      (m_if1),
      .clear       (clear),
      .groups_done (gd[1])
   );

   int n_pass  = 0;
   int n_total = 0;

   task automatic check(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model state: per-channel running sum and sample count, one pending output per instance.
   bit chk_en = 1'b0;
   int msum [2][8];
   int mcnt [2][8];
   bit ev   [2];
   int ed   [2];
   int eu   [2];
   int done_m [2];
   bit rdy_m;
   bit acc_m;
   int grp;

   initial begin
      for (int d = 0; d < 2; d++) begin
         ev[d] = 1'b0; ed[d] = 0; eu[d] = 0; done_m[d] = 0;
         for (int c = 0; c < 8; c++) begin
            msum[d][c] = 0; mcnt[d][c] = 0;
         end
      end
   end

   // Compare DUT outputs with the model, then advance the model by what happens at the next edge.
   always @(negedge CLK) begin
      if (chk_en) begin
         for (int d = 0; d < 2; d++) begin
            grp   = (d == 0) ? 4 : 1;
            rdy_m = !rst && (!ev[d] || m_rdy[d]);
            check($sformatf("s_tready[%0d]", d), int'(o_sr[d]), int'(rdy_m));
            check($sformatf("m_tvalid[%0d]", d), int'(o_mv[d]), int'(ev[d]));
            if (ev[d]) begin
               check($sformatf("m_tdata[%0d]", d), int'(o_md[d]), ed[d]);
               check($sformatf("m_tuser[%0d]", d), int'(o_mu[d]), eu[d]);
            end
            check($sformatf("groups_done[%0d]", d), int'(gd[d]), done_m[d]);
            acc_m = s_tv[d] && rdy_m;
            if (ev[d] && m_rdy[d]) begin
               ev[d]     = 1'b0;
               done_m[d] = (done_m[d] + 1) % 65536;
            end
            if (rst) begin
               ev[d] = 1'b0;
               done_m[d] = 0;
               for (int c = 0; c < 8; c++) begin
                  msum[d][c] = 0; mcnt[d][c] = 0;
               end
            end else if (clear) begin
               for (int c = 0; c < 8; c++) begin
                  msum[d][c] = 0; mcnt[d][c] = 0;
               end
            end else if (acc_m) begin
               msum[d][s_tu[d]] += int'(s_td[d]);
               mcnt[d][s_tu[d]] += 1;
               if (mcnt[d][s_tu[d]] == grp) begin
                  ed[d] = (msum[d][s_tu[d]] + grp / 2) / grp;
                  eu[d] = int'(s_tu[d]);
                  ev[d] = 1'b1;
                  msum[d][s_tu[d]] = 0;
                  mcnt[d][s_tu[d]] = 0;
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge CLK);
      #2;
   endtask

   // Present one beat and hold it until the DUT takes it (bounded).
   task automatic beat(input int d, input int ch, input int data);
      bit got;
      s_tv[d] = 1'b1;
      s_td[d] = 8'(data);
      s_tu[d] = 3'(ch);
      got = 1'b0;
      for (int i = 0; i < 50 && !got; i++) begin
         #1;
         got = o_sr[d];
         tick();
      end
      if (!got) check("beat_timeout", 0, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      clear = 1'b0;
      for (int d = 0; d < 2; d++) begin
         s_tv[d] = 1'b0; s_td[d] = 8'd0; s_tu[d] = 3'd0; m_rdy[d] = 1'b1;
      end
      tick();
      chk_en = 1'b1;
      check("rst_tvalid", int'(o_mv[0]), 0);
      check("rst_tdata", int'(o_md[0]), 0);
      check("rst_groups", int'(gd[0]), 0);
      check("rst_tready", int'(o_sr[0]), 0);
      tick();
      rst = 1'b0;
      #1;
      check("tready_after_rst", int'(o_sr[0]), 1);

      // 1: ch5 10,11,12,13 -> (46+2)>>2 = 12
      beat(0, 5, 10); beat(0, 5, 11); beat(0, 5, 12); beat(0, 5, 13);
      s_tv[0] = 1'b0;
      check("t1_valid", int'(o_mv[0]), 1);
      check("t1_data", int'(o_md[0]), 12);
      check("t1_user", int'(o_mu[0]), 5);
      tick();
      check("t1_groups", int'(gd[0]), 1);

      // 2: interleaved ch0 all 255 and ch1 0,1,0,1
      beat(0, 0, 255); beat(0, 1, 0); beat(0, 0, 255); beat(0, 1, 1);
      beat(0, 0, 255); beat(0, 1, 0); beat(0, 0, 255);
      check("t2_ch0_data", int'(o_md[0]), 255);
      check("t2_ch0_user", int'(o_mu[0]), 0);
      beat(0, 1, 1);
      s_tv[0] = 1'b0;
      check("t2_ch1_data", int'(o_md[0]), 1);
      check("t2_ch1_user", int'(o_mu[0]), 1);
      tick();
      check("t2_groups", int'(gd[0]), 3);

      // 3: backpressure on a ch2 group (8,8,8,9 -> 8) with a waiting beat
      m_rdy[0] = 1'b0;
      beat(0, 2, 8); beat(0, 2, 8); beat(0, 2, 8); beat(0, 2, 9);
      s_tv[0] = 1'b1; s_td[0] = 8'd20; s_tu[0] = 3'd2;
      for (int i = 0; i < 5; i++) begin
         #1;
         check("t3_hold_valid", int'(o_mv[0]), 1);
         check("t3_hold_data", int'(o_md[0]), 8);
         check("t3_hold_ready", int'(o_sr[0]), 0);
         tick();
      end
      m_rdy[0] = 1'b1;
      #1;
      check("t3_release_ready", int'(o_sr[0]), 1);
      tick();
      beat(0, 2, 20); beat(0, 2, 20); beat(0, 2, 20);
      s_tv[0] = 1'b0;
      check("t3_next_data", int'(o_md[0]), 20);
      tick();

      // 4: clear mid-group, beat accepted alongside clear is dropped
      beat(0, 3, 100); beat(0, 3, 100);
      s_tv[0] = 1'b1; s_td[0] = 8'd77; s_tu[0] = 3'd3; clear = 1'b1;
      #1;
      check("t4_ready_with_clear", int'(o_sr[0]), 1);
      tick();
      clear = 1'b0;
      beat(0, 3, 4); beat(0, 3, 4); beat(0, 3, 4); beat(0, 3, 4);
      s_tv[0] = 1'b0;
      check("t4_data", int'(o_md[0]), 4);
      check("t4_user", int'(o_mu[0]), 3);
      tick();

      // 5: reset with a partial ch4 group and a full output register (ch7 1..4 -> 3)
      beat(0, 4, 50); beat(0, 4, 50);
      m_rdy[0] = 1'b0;
      beat(0, 7, 1); beat(0, 7, 2); beat(0, 7, 3); beat(0, 7, 4);
      s_tv[0] = 1'b0;
      check("t5_full_data", int'(o_md[0]), 3);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("t5_rst_valid", int'(o_mv[0]), 0);
      check("t5_rst_groups", int'(gd[0]), 0);
      m_rdy[0] = 1'b1;
      tick();
      beat(0, 4, 60); beat(0, 4, 60); beat(0, 4, 60); beat(0, 4, 61);
      s_tv[0] = 1'b0;
      check("t5_data", int'(o_md[0]), 60);
      check("t5_user", int'(o_mu[0]), 4);
      tick();
      check("t5_groups", int'(gd[0]), 1);

      // 6: one-sample groups are a registered pass-through
      beat(1, 6, 7);
      check("t6_data0", int'(o_md[1]), 7);
      check("t6_user0", int'(o_mu[1]), 6);
      beat(1, 6, 200);
      check("t6_data1", int'(o_md[1]), 200);
      beat(1, 6, 3);
      s_tv[1] = 1'b0;
      check("t6_data2", int'(o_md[1]), 3);
      tick();
      check("t6_groups", int'(gd[1]), 3);

      tick();
      chk_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
